// File: rtl/ir_nec_pkg.sv
// Shared state encodings and NEC unit lengths for the IR transmit path.
package ir_nec_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE       = 3'd0;
  localparam state_t LEAD_MARK  = 3'd1;
  localparam state_t LEAD_SPACE = 3'd2;
  localparam state_t BIT_MARK   = 3'd3;
  localparam state_t BIT_SPACE  = 3'd4;
  localparam state_t STOP_MARK  = 3'd5;
  localparam state_t GAP        = 3'd6;

  localparam int unsigned LEAD_MARK_U  = 16;
  localparam int unsigned LEAD_SPACE_U = 8;
  localparam int unsigned RPT_SPACE_U  = 4;
  localparam int unsigned BIT_MARK_U   = 1;
  localparam int unsigned ZERO_SPACE_U = 1;
  localparam int unsigned ONE_SPACE_U  = 3;
  localparam int unsigned STOP_MARK_U  = 1;
  localparam int unsigned NEC_BITS     = 32;

  function automatic logic is_mark(state_t s);
    return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
  endfunction

endpackage

// File: rtl/ir_tx_nec_if.sv
// Request/response handshake between a frame source and the NEC transmitter.
interface ir_tx_nec_if;
  logic       start;
  logic       rpt;
  logic [7:0] addr;
  logic [7:0] cmd;
  logic       ready;
  logic       done;

  modport master (output start, output rpt, output addr, output cmd,
                  input ready, input done);
  modport slave  (input start, input rpt, input addr, input cmd,
                  output ready, output done);
endinterface

// File: rtl/ir_carrier_gen.sv
// Carrier phase generator; phase restarts at 0 in the first cycle of each mark.
module ir_carrier_gen #(
  parameter int unsigned CARRIER_DIV = 1316,
  parameter int unsigned CARRIER_HI  = 439
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_clear,
  output logic carrier
);

  localparam int unsigned PhW = $clog2(CARRIER_DIV);

  logic [PhW-1:0] phase_q, phase_d;
  logic           carrier_q;

  always_comb begin
    phase_d = phase_q + PhW'(1);
    if (sync_clear || (phase_q == PhW'(CARRIER_DIV - 1))) begin
      phase_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= '0;
      carrier_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      carrier_q <= (phase_d < PhW'(CARRIER_HI));
    end
  end

  assign carrier = carrier_q;

endmodule

// File: rtl/ir_tx_nec.sv
// NEC infrared transmitter: frame/repeat FSM, unit timer and shift register.
module ir_tx_nec
  import ir_nec_pkg::*;
#(
  parameter int unsigned UNIT_CYC    = 28125,
  parameter int unsigned CARRIER_DIV = 1316,
  parameter int unsigned CARRIER_HI  = 439,
  parameter int unsigned GAP_UNITS   = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  ir_tx_nec_if.slave     bus,
  output logic           envelope,
  output logic           ir_out
);

  localparam int unsigned CycW = $clog2(UNIT_CYC);

  state_t          state_q, state_d;
  logic [CycW-1:0] cyc_q, cyc_d;
  logic [15:0]     unit_q, unit_d, seg_len;
  logic [4:0]      bit_q, bit_d;
  logic [31:0]     sr_q, sr_d;
  logic            rpt_q, rpt_d;
  logic            env_q, env_d;
  logic            done_q, done_d;
  logic            tick, seg_last, sync_clear, carrier;

  always_comb begin
    unique case (state_q)
      LEAD_MARK:  seg_len = 16'(LEAD_MARK_U);
      LEAD_SPACE: seg_len = rpt_q ? 16'(RPT_SPACE_U) : 16'(LEAD_SPACE_U);
      BIT_MARK:   seg_len = 16'(BIT_MARK_U);
      BIT_SPACE:  seg_len = sr_q[0] ? 16'(ONE_SPACE_U) : 16'(ZERO_SPACE_U);
      STOP_MARK:  seg_len = 16'(STOP_MARK_U);
      GAP:        seg_len = 16'(GAP_UNITS);
      default:    seg_len = 16'd1;
    endcase
  end

  assign tick     = (cyc_q == CycW'(UNIT_CYC - 1));
  assign seg_last = tick && (unit_q == seg_len - 16'd1);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    unit_d  = unit_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    rpt_d   = rpt_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      cyc_d  = '0;
      unit_d = '0;
      if (bus.start) begin
        sr_d    = {~bus.cmd, bus.cmd, ~bus.addr, bus.addr};
        rpt_d   = bus.rpt;
        bit_d   = '0;
        state_d = LEAD_MARK;
      end
    end else begin
      cyc_d = tick ? '0 : cyc_q + CycW'(1);
      if (tick) begin
        unit_d = seg_last ? 16'd0 : unit_q + 16'd1;
      end
      if (seg_last) begin
        unique case (state_q)
          LEAD_MARK:  state_d = LEAD_SPACE;
          LEAD_SPACE: state_d = rpt_q ? STOP_MARK : BIT_MARK;
          BIT_MARK:   state_d = BIT_SPACE;
          BIT_SPACE: begin
            sr_d    = {1'b0, sr_q[31:1]};
            bit_d   = bit_q + 5'd1;
            state_d = (bit_q == 5'(NEC_BITS - 1)) ? STOP_MARK : BIT_MARK;
          end
          STOP_MARK:  state_d = GAP;
          GAP: begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
          default:    state_d = IDLE;
        endcase
      end
    end
  end

  // Mark entries always come from a non-mark state, so this fires once per mark.
  assign env_d      = is_mark(state_d);
  assign sync_clear = env_d && !is_mark(state_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      unit_q  <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      rpt_q   <= 1'b0;
      env_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      unit_q  <= unit_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      rpt_q   <= rpt_d;
      env_q   <= env_d;
      done_q  <= done_d;
    end
  end

  ir_carrier_gen #(
    .CARRIER_DIV (CARRIER_DIV),
    .CARRIER_HI  (CARRIER_HI)
  ) u_carrier (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync_clear (sync_clear),
    .carrier    (carrier)
  );

  assign bus.ready = (state_q == IDLE);
  assign bus.done  = done_q;
  assign envelope  = env_q;
  assign ir_out    = env_q & carrier;

endmodule

// File: tb/tb_ir_tx_nec.sv
// Directed bench for ir_tx_nec with scaled timing (20-cycle units, 4-cycle carrier).
module tb_ir_tx_nec;

  localparam int MaxN = 4000;
  localparam int Unit = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic envelope, ir_out;
  int   checks = 0;
  int   errors = 0;

  logic env_tr [1:MaxN];
  logic ir_tr  [1:MaxN];
  logic rdy_tr [1:MaxN];
  logic done_tr[1:MaxN];
  logic exp_env [1:MaxN];
  logic exp_ir  [1:MaxN];
  logic exp_rdy [1:MaxN];
  logic exp_done[1:MaxN];
  int   exp_pos;

  ir_tx_nec_if bus ();

  ir_tx_nec #(
    .UNIT_CYC    (20),
    .CARRIER_DIV (4),
    .CARRIER_HI  (1),
    .GAP_UNITS   (64)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .envelope (envelope),
    .ir_out   (ir_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put_seg(input logic mark, input int units);
    for (int k = 0; k < units * Unit; k++) begin
      exp_env[exp_pos] = mark;
      exp_ir[exp_pos]  = mark && ((k % 4) == 0);
      exp_pos++;
    end
  endtask

  // Expected per-cycle waveform, cycle 1 = first cycle after acceptance.
  task automatic build_exp(input logic [7:0] a, input logic [7:0] c, input logic r,
                           output int n);
    logic [31:0] w;
    w = {~c, c, ~a, a};
    for (int i = 1; i <= MaxN; i++) begin
      exp_env[i] = 1'b0; exp_ir[i] = 1'b0; exp_rdy[i] = 1'b0; exp_done[i] = 1'b0;
    end
    exp_pos = 1;
    put_seg(1'b1, 16);
    if (r) begin
      put_seg(1'b0, 4);
    end else begin
      put_seg(1'b0, 8);
      for (int i = 0; i < 32; i++) begin
        put_seg(1'b1, 1);
        put_seg(1'b0, w[i] ? 3 : 1);
      end
    end
    put_seg(1'b1, 1);
    put_seg(1'b0, 64);
    n = exp_pos;
    exp_rdy[n]  = 1'b1;
    exp_done[n] = 1'b1;
  endtask

  task automatic start_frame(input logic [7:0] a, input logic [7:0] c, input logic r);
    @(negedge clk);
    bus.addr = a; bus.cmd = c; bus.rpt = r; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // mode 1: ignored start + input changes mid-frame, then start held high into done.
  task automatic capture(input int n, input int mode);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (mode == 1) begin
        if (i == 500) begin
          bus.start = 1'b1; bus.addr = 8'hFF; bus.cmd = 8'h00; bus.rpt = 1'b1;
        end
        if (i == 501) bus.start = 1'b0;
        if (i == 3000) begin
          bus.start = 1'b1; bus.addr = 8'h3C; bus.cmd = 8'hA5; bus.rpt = 1'b0;
        end
      end
      env_tr[i] = envelope; ir_tr[i] = ir_out; rdy_tr[i] = bus.ready; done_tr[i] = bus.done;
    end
  endtask

  task automatic check_frame(input string tag, input int n, input logic full,
                             input int exp_word, input int exp_last);
    int env_bad, ir_bad, hs_bad, last_hi, run;
    int runs[$];
    logic [31:0] word;
    env_bad = 0; ir_bad = 0; hs_bad = 0; last_hi = 0;
    for (int i = 1; i <= n; i++) begin
      if (env_tr[i] !== exp_env[i]) env_bad++;
      if (ir_tr[i] !== exp_ir[i]) ir_bad++;
      if ((rdy_tr[i] !== exp_rdy[i]) || (done_tr[i] !== exp_done[i])) hs_bad++;
      if (env_tr[i] === 1'b1) last_hi = i;
    end
    check({tag, " envelope mismatch cycles"}, env_bad, 0);
    check({tag, " ir_out mismatch cycles"}, ir_bad, 0);
    check({tag, " ready/done mismatch cycles"}, hs_bad, 0);
    check({tag, " last envelope-high cycle"}, last_hi, exp_last);
    if (full) begin
      run = 1;
      for (int i = 2; i <= n + 1; i++) begin
        if ((i > n) || (env_tr[i] !== env_tr[i-1])) begin
          runs.push_back(run);
          run = 1;
        end else begin
          run++;
        end
      end
      word = '0;
      if (runs.size() >= 67) begin
        for (int i = 0; i < 32; i++) word[i] = (runs[3 + 2 * i] == 3 * Unit);
      end
      check({tag, " decoded bytes"}, int'(word), exp_word);
    end
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.rpt = 1'b0; bus.addr = 8'h00; bus.cmd = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ready", int'(bus.ready), 1);
    check("reset done", int'(bus.done), 0);
    check("reset envelope", int'(envelope), 0);
    check("reset ir_out", int'(ir_out), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All-zero address/command.
    build_exp(8'h00, 8'h00, 1'b0, n);
    check("full frame length model", n, 3701);
    start_frame(8'h00, 8'h00, 1'b0);
    capture(n, 0);
    check_frame("frame 00/00", n, 1'b1, 32'hFF00FF00, 2420);

    // 0x59/0x16 with disturbances; start held high into done.
    build_exp(8'h59, 8'h16, 1'b0, n);
    start_frame(8'h59, 8'h16, 1'b0);
    capture(n, 1);
    check_frame("frame 59/16", n, 1'b1, 32'hE916A659, 2420);
    @(posedge clk);
    #1 bus.start = 1'b0;
    build_exp(8'h3C, 8'hA5, 1'b0, n);
    capture(n, 0);
    check_frame("back-to-back 3C/A5", n, 1'b1, 32'h5AA5C33C, 2420);

    // Repeat code.
    build_exp(8'h00, 8'h00, 1'b1, n);
    check("repeat length model", n, 1701);
    start_frame(8'hAA, 8'h55, 1'b1);
    capture(n, 0);
    check_frame("repeat", n, 1'b0, 0, 420);

    // Asynchronous reset mid-frame.
    start_frame(8'h12, 8'h34, 1'b0);
    repeat (1000) @(negedge clk);
    check("busy before reset", int'(bus.ready), 0);
    rst_n = 1'b0;
    #1;
    check("async reset ready", int'(bus.ready), 1);
    check("async reset envelope", int'(envelope), 0);
    check("async reset ir_out", int'(ir_out), 0);
    check("async reset done", int'(bus.done), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("idle after release ready", int'(bus.ready), 1);
    check("idle after release envelope", int'(envelope), 0);
    build_exp(8'h12, 8'h34, 1'b0, n);
    start_frame(8'h12, 8'h34, 1'b0);
    capture(n, 0);
    check_frame("post-reset 12/34", n, 1'b1, 32'hCB34ED12, 2420);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
